// File: rtl/example_design_stream_gen.sv
// example_design_stream_gen
//   Multi-channel burst stimulus generator. On a start in IDLE it latches the
//   pattern mode and burst length, then every channel independently emits
//   i_burst_len beats of a deterministic pattern (counter, Galois LFSR,
//   constant or walking-one) over its own valid/ready stream. When every
//   channel has drained, o_done pulses for one cycle. An abort in RUN drops
//   straight back to IDLE without a done pulse.
//
// Ports
//   clk, rst_n   : rising-edge clock, synchronous active-low reset
//   i_start      : start a burst (IDLE only)
//   i_abort      : abandon the burst (RUN only)
//   i_mode       : 0 counter, 1 LFSR, 2 constant, 3 walking-one
//   i_burst_len  : beats per channel (0 gives an immediate done)
//   i_const      : value used by constant mode
//   o_data       : channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   o_valid      : per-channel valid
//   i_ready      : per-channel ready
//   o_busy       : high while in RUN
//   o_done       : one-cycle completion pulse
module example_design_stream_gen #(
  parameter int          DATA_WIDTH   = 8,
  parameter int          NUM_CHANNELS = 2,
  parameter int          LEN_WIDTH    = 8,
  parameter int unsigned LFSR_POLY    = 'hB8,
  parameter int          LFSR_SEED    = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_start,
  input  logic                               i_abort,
  input  logic [1:0]                         i_mode,
  input  logic [LEN_WIDTH-1:0]               i_burst_len,
  input  logic [DATA_WIDTH-1:0]              i_const,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_data,
  output logic [NUM_CHANNELS-1:0]            o_valid,
  input  logic [NUM_CHANNELS-1:0]            i_ready,
  output logic                               o_busy,
  output logic                               o_done
);

  localparam int unsigned NC = NUM_CHANNELS;
  localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(LFSR_POLY);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {M_CNT, M_LFSR, M_CONST, M_WALK} mode_e;

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_CHANNELS-1:0][LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [NUM_CHANNELS-1:0]                 valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Per-channel LFSR seed; an all-zero seed would lock the LFSR, so use 1.
  function automatic logic [DATA_WIDTH-1:0] chan_seed(input int unsigned c);
    logic [DATA_WIDTH-1:0] s;
    s = DATA_WIDTH'(LFSR_SEED + int'(c));
    if (s == '0) s = DATA_WIDTH'(1);
    return s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] first_val(input mode_e m, input int unsigned c,
                                                      input logic [DATA_WIDTH-1:0] k);
    logic [DATA_WIDTH-1:0] v;
    case (m)
      M_CNT:   v = '0;
      M_LFSR:  v = chan_seed(c);
      M_CONST: v = k;
      default: v = DATA_WIDTH'(1);
    endcase
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_val(input mode_e m,
                                                     input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] n;
    case (m)
      M_CNT:   n = s + DATA_WIDTH'(1);
      M_LFSR:  n = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
      M_CONST: n = s;
      default: n = {s[DATA_WIDTH-2:0], s[DATA_WIDTH-1]};
    endcase
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mode_d = mode_e'(i_mode);
          if (i_burst_len != '0) begin
            for (int unsigned c = 0; c < NC; c++) begin
              rem_d[c]   = i_burst_len;
              valid_d[c] = 1'b1;
              data_d[c]  = first_val(mode_e'(i_mode), c, i_const);
            end
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (i_abort) begin
          // Abort wins over any transfer on the same edge: nothing advances.
          valid_d = '0;
          rem_d   = '0;
          state_d = S_IDLE;
        end else begin
          for (int unsigned c = 0; c < NC; c++) begin
            if (valid_q[c] && i_ready[c]) begin
              data_d[c] = next_val(mode_q, data_q[c]);
              rem_d[c]  = rem_q[c] - LEN_WIDTH'(1);
              if (rem_q[c] == LEN_WIDTH'(1)) valid_d[c] = 1'b0;
            end
          end
          // valid tracks remaining != 0, so all-clear means every channel drained.
          if (valid_d == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_CNT;
      data_q  <= '0;
      rem_q   <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_example_design_stream_gen.sv
// Testbench for example_design_stream_gen: directed scenarios plus randomized
// bursts, checked against a beat-indexed pattern model.
module tb_example_design_stream_gen;
  localparam int DW   = 8;
  localparam int NC   = 2;
  localparam int LW   = 8;
  localparam int POLY = 'hB8;
  localparam int SEED = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0, i_abort = 1'b0;
  logic [1:0] i_mode = '0;
  logic [LW-1:0] i_burst_len = '0;
  logic [DW-1:0] i_const = '0;
  logic [NC*DW-1:0] o_data;
  logic [NC-1:0] o_valid;
  logic [NC-1:0] i_ready = '0;
  logic o_busy, o_done;

  // 4-bit single-channel instance for counter wrap-around.
  logic s_start = 1'b0;
  logic [7:0] s_len = '0;
  logic [3:0] s_const = '0;
  logic [3:0] s_data;
  logic [0:0] s_valid;
  logic [0:0] s_ready = '0;
  logic s_busy, s_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  example_design_stream_gen #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .LEN_WIDTH(LW), .LFSR_POLY(POLY), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
    .i_burst_len(i_burst_len), .i_const(i_const), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
  );

  example_design_stream_gen #(
    .DATA_WIDTH(4), .NUM_CHANNELS(1), .LEN_WIDTH(8), .LFSR_POLY('hC), .LFSR_SEED(1)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_abort(1'b0), .i_mode(2'd0),
    .i_burst_len(s_len), .i_const(s_const), .o_data(s_data), .o_valid(s_valid),
    .i_ready(s_ready), .o_busy(s_busy), .o_done(s_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Value of beat number 'beat' on channel 'ch', straight from the pattern definitions.
  function automatic int unsigned model_val(input int unsigned mode, input int unsigned ch,
                                            input int unsigned beat, input int unsigned w,
                                            input int unsigned poly, input int unsigned kval);
    int unsigned mask;
    int unsigned s;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    case (mode)
      0: return beat % (mask + 1);
      1: begin
        s = (SEED + ch) & mask;
        if (s == 0) s = 1;
        for (int unsigned i = 0; i < beat; i++)
          s = (s % 2 == 1) ? ((s / 2) ^ poly) : (s / 2);
        return s;
      end
      2: return kval & mask;
      default: return 32'd1 << (beat % w);
    endcase
  endfunction

  // Drives one burst from a negedge and checks every cycle until done/abort.
  // abort_at / start_poke: cycle index into RUN where the pulse is applied (-1 = never).
  // stall1: number of initial RUN cycles with channel 1 ready forced low.
  task automatic run_burst(input int unsigned mode, input int unsigned len,
                           input int unsigned kval, input int unsigned rdy_pct,
                           input int abort_at, input int start_poke, input int stall1);
    int unsigned sent[NC];
    logic [NC-1:0] rdy;
    int cyc;
    bit fin;
    bit all_sent;
    int unsigned tot;
    for (int c = 0; c < NC; c++) sent[c] = 0;
    i_start = 1'b1;
    i_mode = 2'(mode);
    i_burst_len = LW'(len);
    i_const = DW'(kval);
    @(negedge clk);
    i_start = 1'b0;
    if (len == 0) begin
      check_eq("zero_done", o_done, 1);
      check_eq("zero_valid", o_valid, 0);
      check_eq("zero_busy", o_busy, 0);
      @(negedge clk);
      check_eq("zero_done_clr", o_done, 0);
      return;
    end
    cyc = 0;
    fin = 0;
    while (!fin) begin
      for (int c = 0; c < NC; c++) begin
        check_eq($sformatf("valid%0d", c), o_valid[c], sent[c] < len);
        if (sent[c] < len)
          check_eq($sformatf("data%0d_m%0d_b%0d", c, mode, sent[c]), o_data[c*DW +: DW],
                   model_val(mode, c, sent[c], DW, POLY, kval));
      end
      check_eq("busy", o_busy, 1);
      check_eq("done_early", o_done, 0);
      for (int c = 0; c < NC; c++) begin
        rdy[c] = ($urandom_range(99) < rdy_pct);
        if (c == 1 && cyc < stall1) rdy[c] = 1'b0;
      end
      i_ready = rdy;
      i_start = (cyc == start_poke);
      i_abort = (cyc == abort_at);
      if (i_abort) begin
        @(negedge clk);
        i_abort = 1'b0;
        i_start = 1'b0;
        check_eq("abort_valid", o_valid, 0);
        check_eq("abort_busy", o_busy, 0);
        check_eq("abort_done", o_done, 0);
        @(negedge clk);
        check_eq("abort_done_later", o_done, 0);
        fin = 1;
      end else begin
        all_sent = 1;
        for (int c = 0; c < NC; c++) begin
          if (sent[c] < len && rdy[c]) sent[c]++;
          if (sent[c] != len) all_sent = 0;
        end
        @(negedge clk);
        i_start = 1'b0;
        cyc++;
        if (all_sent) begin
          check_eq("fin_done", o_done, 1);
          check_eq("fin_busy", o_busy, 0);
          check_eq("fin_valid", o_valid, 0);
          @(negedge clk);
          check_eq("fin_done_clr", o_done, 0);
          fin = 1;
        end else if (cyc > 20 * int'(len) + 50) begin
          tot = 0;
          for (int c = 0; c < NC; c++) tot += sent[c];
          check_eq("timeout_beats", tot, len * NC);
          fin = 1;
        end
      end
    end
    i_ready = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_data", o_data, 0);
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_burst(0, 4, 0, 100, -1, -1, 0);        // counter, full throughput
    run_burst(0, 4, 0, 100, -1, -1, 3);        // ch1 backpressured 3 cycles
    run_burst(1, 6, 0, 100, -1, -1, 0);        // LFSR
    run_burst(3, 10, 0, 100, -1, -1, 0);       // walking-one wrap
    run_burst(2, 5, 'h5A, 70, -1, -1, 0);      // constant
    run_burst(0, 8, 0, 100, 2, -1, 0);         // abort on third beat
    run_burst(1, 3, 0, 100, -1, -1, 0);        // restart after abort
    run_burst(0, 6, 0, 60, -1, 1, 0);          // start ignored in RUN
    run_burst(0, 0, 0, 100, -1, -1, 0);        // zero length

    // Reset in the middle of a burst.
    i_start = 1'b1; i_mode = 2'd0; i_burst_len = 8'd8; i_ready = '1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_data", o_data, 0);
    check_eq("mid_rst_valid", o_valid, 0);
    check_eq("mid_rst_busy", o_busy, 0);
    check_eq("mid_rst_done", o_done, 0);
    rst_n = 1'b1;
    i_ready = '0;
    @(negedge clk);
    check_eq("post_rst_done", o_done, 0);
    run_burst(1, 4, 0, 80, -1, -1, 0);

    for (int n = 0; n < 12; n++) begin
      int unsigned m, l, pct;
      int ab, sp;
      m = $urandom_range(3);
      l = $urandom_range(20);
      pct = $urandom_range(30, 100);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(l + 2)) : -1;
      sp = ($urandom_range(1) == 0) ? int'($urandom_range(l + 2)) : -1;
      run_burst(m, l, $urandom, pct, ab, sp, 0);
    end

    // 4-bit counter wraps after F.
    s_start = 1'b1; s_len = 8'd17; s_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int unsigned i = 0; i < 17; i++) begin
      check_eq($sformatf("w4_valid%0d", i), s_valid, 1);
      check_eq($sformatf("w4_data%0d", i), s_data, model_val(0, 0, i, 4, 'hC, 0));
      @(negedge clk);
    end
    check_eq("w4_done", s_done, 1);
    check_eq("w4_valid_end", s_valid, 0);
    check_eq("w4_busy_end", s_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
